// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the synchronous IMEM read port
// and loads the IF/ID register, with stall, redirect-flush and misaligned-target trap.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     IMEM_AW   = 10,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_if,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic                if_id_valid,
    output logic [XLEN-1:0]     if_id_pc,
    output logic [XLEN-1:0]     if_id_pc4,
    output logic [31:0]         if_id_instr,
    output logic                misaligned_err,
    output logic [31:0]         fetch_count
);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            misaligned_err_q, misaligned_err_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic            misalign;
    logic            fetch_valid;

    assign misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_valid = (state_q == ST_RUN);

    // Next-state, next-PC and IF/ID load.
    always_comb begin
        state_d          = state_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc4_d      = if_id_pc4_q;
        if_id_instr_d    = if_id_instr_q;
        fetch_count_d    = fetch_count_q;
        misaligned_err_d = misaligned_err_q | misalign;

        case (state_q)
            ST_RESET: state_d = ST_FILL;
            ST_FILL:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_FAULT;
        endcase
        if (misalign) begin
            state_d = ST_FAULT;
        end

        // RESET/FILL hold the PC so the first word read is RESET_PC (or the redirect target).
        if (reset) begin
            pc_d = RESET_PC;
        end else if (state_q == ST_FAULT) begin
            pc_d = pc_q;
        end else if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall_if || !fetch_valid) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + PC_STEP;
        end

        if (redirect_valid || !fetch_valid) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            if_id_pc_d    = '0;
            if_id_pc4_d   = '0;
        end else if (!stall_if) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem_rdata;
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_q + PC_STEP;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    assign imem_addr = pc_d[IMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RESET;
            pc_q             <= RESET_PC;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= '0;
            if_id_pc4_q      <= '0;
            if_id_instr_q    <= NOP_INSTR;
            misaligned_err_q <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc4_q      <= if_id_pc4_d;
            if_id_instr_q    <= if_id_instr_d;
            misaligned_err_q <= misaligned_err_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc4      = if_id_pc4_q;
    assign if_id_instr    = if_id_instr_q;
    assign misaligned_err = misaligned_err_q;
    assign fetch_count    = fetch_count_q;

endmodule
